// File: rtl/step_enable_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : step_enable_gen
// Function : Debounced push-button to single-step / free-run enable pulses.
// Revision : 1.0
// ============================================================================
module step_enable_gen #(
    parameter int DEB_CYCLES = 4,
    parameter int PRESCALE   = 10
) (
    input  logic clk,
    input  logic asyn_reset,
    input  logic btn_in,
    input  logic mode,
    output logic ena,
    output logic run,
    output logic btn_db
);

    localparam int              PW         = $clog2(PRESCALE);
    localparam logic [7:0]      c_DEB_LAST = 8'(DEB_CYCLES - 1);
    localparam logic [PW-1:0]   c_PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_btn_db;
    logic [7:0]    r_deb_cnt;
    logic          r_press;
    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic          r_ena;
    logic          r_run;

    logic          w_differ;
    logic          w_deb_done;
    state_t        w_state_next;
    logic [PW-1:0] w_presc_next;
    logic          w_ena_next;

    assign w_differ   = r_sync2 ^ r_btn_db;
    assign w_deb_done = w_differ && (r_deb_cnt == c_DEB_LAST);

    // Synchronizer, debounce counter and press detector.
    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_btn_db  <= 1'b0;
            r_deb_cnt <= 8'd0;
            r_press   <= 1'b0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
            if (w_deb_done) begin
                r_btn_db  <= ~r_btn_db;
                r_deb_cnt <= 8'd0;
            end else if (w_differ) begin
                r_deb_cnt <= r_deb_cnt + 8'd1;
            end else begin
                r_deb_cnt <= 8'd0;
            end
            r_press <= w_deb_done & ~r_btn_db;
        end
    end

    // A press or a mode drop while running wins over a coincident wrap.
    always_comb begin
        w_state_next = r_state;
        w_presc_next = r_presc;
        w_ena_next   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_presc_next = '0;
                if (r_press) begin
                    if (mode) begin
                        w_state_next = ST_RUN;
                    end else begin
                        w_ena_next = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (r_press || !mode) begin
                    w_state_next = ST_IDLE;
                    w_presc_next = '0;
                end else if (r_presc == c_PRE_LAST) begin
                    w_presc_next = '0;
                    w_ena_next   = 1'b1;
                end else begin
                    w_presc_next = r_presc + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_presc_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            r_state <= ST_IDLE;
            r_presc <= '0;
            r_ena   <= 1'b0;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_presc <= w_presc_next;
            r_ena   <= w_ena_next;
            r_run   <= (w_state_next == ST_RUN);
        end
    end

    assign ena    = r_ena;
    assign run    = r_run;
    assign btn_db = r_btn_db;

endmodule
`default_nettype wire

// File: tb/tb_step_enable_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_step_enable_gen
// Function : Segment table plus directed corner sequences for step_enable_gen.
// Revision : 1.0
// ============================================================================
module tb_step_enable_gen;

    logic clk;
    logic asyn_reset;
    logic btn_in;
    logic mode;
    logic ena;
    logic run;
    logic btn_db;

    step_enable_gen #(
        .DEB_CYCLES (4),
        .PRESCALE   (10)
    ) u_dut (
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .btn_in     (btn_in),
        .mode       (mode),
        .ena        (ena),
        .run        (run),
        .btn_db     (btn_db)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic btn;
        logic mode;
        int   n;
        int   exp_ena;
        int   exp_rise;
        logic exp_run;
        logic exp_db;
    } seg_t;

    seg_t segs[16];

    int   n_pass;
    int   n_total;
    int   cyc;
    int   ena_cnt;
    int   rise_cnt;
    logic prev_ena;
    logic prev_db;

    task automatic chk(input string name, input int act, input int exp_v);
        n_total++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        chk("ena_not_consecutive", int'(prev_ena & ena), 0);
        if (ena) ena_cnt++;
        if (btn_db && !prev_db) rise_cnt++;
        prev_ena = ena;
        prev_db  = btn_db;
    endtask

    task automatic wait_run(output int t);
        int k;
        k = 0;
        while (!run && k < 40) begin
            step();
            k++;
        end
        chk("wait_run_in_budget", int'(run), 1);
        t = cyc;
    endtask

    task automatic wait_ena(input string name, input int t0, input int gap);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!ena && k < 20);
        chk(name, cyc - t0, gap);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t_run;
        int t_ena;

        n_pass = 0; n_total = 0; cyc = 0;
        ena_cnt = 0; rise_cnt = 0; prev_ena = 1'b0; prev_db = 1'b0;

        //          btn   mode  n   ena rise run   db
        segs[0]  = '{1'b0, 1'b0, 20, 0, 0, 1'b0, 1'b0};
        segs[1]  = '{1'b1, 1'b0, 3,  0, 0, 1'b0, 1'b0};
        segs[2]  = '{1'b0, 1'b0, 10, 0, 0, 1'b0, 1'b0};
        segs[3]  = '{1'b1, 1'b0, 1,  0, 0, 1'b0, 1'b0};
        segs[4]  = '{1'b0, 1'b0, 1,  0, 0, 1'b0, 1'b0};
        segs[5]  = '{1'b1, 1'b0, 1,  0, 0, 1'b0, 1'b0};
        segs[6]  = '{1'b0, 1'b0, 1,  0, 0, 1'b0, 1'b0};
        segs[7]  = '{1'b1, 1'b0, 1,  0, 0, 1'b0, 1'b0};
        segs[8]  = '{1'b0, 1'b0, 1,  0, 0, 1'b0, 1'b0};
        segs[9]  = '{1'b1, 1'b0, 30, 1, 1, 1'b0, 1'b1};
        segs[10] = '{1'b0, 1'b0, 30, 0, 0, 1'b0, 1'b0};
        segs[11] = '{1'b0, 1'b1, 5,  0, 0, 1'b0, 1'b0};
        segs[12] = '{1'b1, 1'b1, 8,  0, 1, 1'b1, 1'b1};
        segs[13] = '{1'b0, 1'b1, 30, 3, 0, 1'b1, 1'b0};
        segs[14] = '{1'b1, 1'b1, 8,  0, 1, 1'b0, 1'b1};
        segs[15] = '{1'b0, 1'b1, 20, 0, 0, 1'b0, 1'b0};

        // Power-on reset.
        asyn_reset = 1'b1; btn_in = 1'b0; mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ena", int'(ena), 0);
        chk("reset_run", int'(run), 0);
        chk("reset_db",  int'(btn_db), 0);
        asyn_reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            btn_in = segs[i].btn;
            mode   = segs[i].mode;
            ena_cnt = 0; rise_cnt = 0;
            for (int c = 0; c < segs[i].n; c++) step();
            chk($sformatf("seg%0d_ena_count", i), ena_cnt, segs[i].exp_ena);
            chk($sformatf("seg%0d_db_rises", i), rise_cnt, segs[i].exp_rise);
            chk($sformatf("seg%0d_run", i), int'(run), int'(segs[i].exp_run));
            chk($sformatf("seg%0d_db", i), int'(btn_db), int'(segs[i].exp_db));
        end

        // Free-run spacing, then mode drop one cycle before a wrap.
        mode = 1'b1; btn_in = 1'b1;
        wait_run(t_run);
        btn_in = 1'b0;
        wait_ena("first_ena_gap", t_run, 10);
        t_ena = cyc;
        wait_ena("second_ena_gap", t_ena, 10);
        repeat (8) step();
        chk("run_before_drop", int'(run), 1);
        mode = 1'b0;
        step();
        chk("mode_drop_run", int'(run), 0);
        chk("mode_drop_ena", int'(ena), 0);
        ena_cnt = 0;
        repeat (15) step();
        chk("mode_drop_no_ena", ena_cnt, 0);

        // Mid-run reset asserted between edges.
        mode = 1'b1; btn_in = 1'b1;
        wait_run(t_run);
        repeat (3) step();
        asyn_reset = 1'b1;
        #2;
        chk("async_rst_ena", int'(ena), 0);
        chk("async_rst_run", int'(run), 0);
        chk("async_rst_db",  int'(btn_db), 0);
        repeat (2) @(posedge clk);
        #1;
        btn_in = 1'b0;
        asyn_reset = 1'b0;
        prev_ena = 1'b0; prev_db = 1'b0; ena_cnt = 0;
        repeat (30) step();
        chk("post_rst_run", int'(run), 0);
        chk("post_rst_no_ena", ena_cnt, 0);

        // Button held through reset release counts as a new press.
        mode = 1'b0; btn_in = 1'b1;
        asyn_reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        asyn_reset = 1'b0;
        prev_ena = 1'b0; prev_db = 1'b0;
        repeat (5) step();
        chk("held_db_k4", int'(btn_db), 0);
        step();
        chk("held_db_k5", int'(btn_db), 1);
        chk("held_ena_k5", int'(ena), 0);
        step();
        chk("held_ena_k6", int'(ena), 1);
        step();
        chk("held_ena_k7", int'(ena), 0);
        btn_in = 1'b0;
        repeat (10) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
